system_top: RTL and testbench
=============================

SYSTEM_TOP -- requirements
Module: system_top

Interface
REQ-001 Parameters (name, default, meaning), shared via the package:
  CLK_HZ, 6250000, system clock frequency
  SPI_HALF_DIV, 2, system clocks per SCLK half-period (SCLK = 1.5625 MHz)
  CMD_READ, 8'h03, command byte sent on MOSI
  WORD_BITS, 16, data bits read per frame
  HALF0, 50, clocks per carrier half-period for bit 0 (62.5 kHz)
  HALF1, 40, clocks per carrier half-period for bit 1 (78.125 kHz)
  DEAD, 2, dead-time clocks at each bridge transition
  CYC_PER_BIT, 16, carrier cycles per data bit
  TRIG_LEN, 8, o_Master_Trig pulse width in clocks
REQ-002 Ports (name, direction, width, meaning):
  i_fpga_clock  in  1  sole clock, rising-edge
  i_Rst_L  in  1  reset, asynchronous, active-low
  i_SPI_MISO  in  1  SPI data from slave
  i_Done_Trig  in  1  async "downstream done" request, rising edge significant
  o_SPI_Clk  out  1  SPI clock, mode 0 (idle low)
  o_SPI_MOSI  out  1  SPI data to slave
  o_SPI_CS_n  out  1  SPI chip select, active-low
  o_Master_Trig  out  1  frame-start trigger pulse
  F1Q1, F1Q4  out  1 each  H-bridge diagonal A gate drives (identical waveform)
  F2Q2, F2Q3  out  1 each  H-bridge diagonal B gate drives (identical waveform)

Function
REQ-003 Top FSM states: IDLE, READ, TRIG, TX, WAIT_DONE; IDLE->READ one clock after reset release.
REQ-004 READ: CS_n low; 24 SCLK cycles, MSB first: 8 bits CMD_READ then 16 bits of MOSI=0; MISO sampled on SCLK rising edge during the last 16; MOSI changes on SCLK falling edge; first bit on MOSI one half-period before first rising edge.
REQ-005 CS_n returns high one half-period after last falling SCLK edge; captured 16-bit word latched; READ->TRIG.
REQ-006 TRIG: o_Master_Trig high exactly TRIG_LEN clocks, then TX.
REQ-007 TX: word bits sent MSB first; each bit = CYC_PER_BIT carrier cycles with H = HALF1 if bit=1 else HALF0.
REQ-008 Carrier cycle (2H clocks): diagonal A high H-DEAD clocks, all low DEAD clocks, diagonal B high H-DEAD clocks, all low DEAD clocks.
REQ-009 Diagonals A and B SHALL never be high in the same clock, including at bit boundaries and reset.
REQ-010 Frequency changes only at carrier-cycle boundaries; no gap between consecutive bits.
REQ-011 After last bit's final dead time, all bridge outputs low; TX->WAIT_DONE.
REQ-012 i_Done_Trig passes a 2-flop synchronizer; a synchronized rising edge in WAIT_DONE moves to READ (next frame).
REQ-013 i_Done_Trig edges outside WAIT_DONE are ignored (not queued); pulses shorter than 2 clocks are not guaranteed detected.
REQ-014 Any word value, including 16'h0000 and 16'hFFFF, is transmitted unchanged.
REQ-015 Frame timing fixed: READ 24*2*SPI_HALF_DIV+overhead clocks; TX duration = sum of per-bit 2*H*CYC_PER_BIT.

Reset
REQ-016 Asynchronous assertion of i_Rst_L low forces: FSM IDLE, CS_n=1, SCLK=0, MOSI=0, Master_Trig=0, all four bridge outputs 0, counters and word cleared.
REQ-017 Reset mid-READ or mid-TX aborts immediately with outputs as REQ-016; restart from IDLE after release.

Structure
REQ-018 Package holds all REQ-001 constants and the FSM state enum.
REQ-019 One sub-module spi_master (byte/word shift, SCLK divider, CS control); FSK/bridge generator and FSM remain in system_top.

Verification
REQ-020 Reset release, MISO driven 16'hA5C3 -> CS_n low, MOSI shows 0x03 then zeros, 24 SCLK pulses at 1.5625 MHz, latched word 16'hA5C3.
REQ-021 After READ -> o_Master_Trig high exactly 8 clocks, then bridge starts with bit 1 (MSB of A5C3): A high 38 clocks, 2 dead, B high 38, 2 dead.
REQ-022 Word 16'h0000 -> 16 bits of 100-clock carrier, total TX 25600 clocks; checker asserts A and B never simultaneously high.
REQ-023 i_Done_Trig 3-clock pulse during TX -> ignored; same pulse in WAIT_DONE -> new READ starts within 4 clocks.
REQ-024 i_Rst_L low mid-TX -> all outputs at reset values same timestep; restart with fresh READ after release.

Source files
------------

// File: rtl/system_top_pkg.sv
//==============================================================================
// Module   : system_top_pkg
// Purpose  : Shared constants and FSM state encoding for the SPI-read /
//            FSK H-bridge transmitter (system_top and spi_master).
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package system_top_pkg;

  localparam int         CLK_HZ       = 6250000;  // system clock frequency
  localparam int         SPI_HALF_DIV = 2;        // clocks per SCLK half-period
  localparam logic [7:0] CMD_READ     = 8'h03;    // command byte on MOSI
  localparam int         WORD_BITS    = 16;       // data bits read per frame
  localparam int         HALF0        = 50;       // carrier half-period, bit 0
  localparam int         HALF1        = 40;       // carrier half-period, bit 1
  localparam int         DEAD         = 2;        // dead-time clocks per transition
  localparam int         CYC_PER_BIT  = 16;       // carrier cycles per data bit
  localparam int         TRIG_LEN     = 8;        // o_Master_Trig width in clocks

  // SPI frame = command byte followed by the data word.
  localparam int         FRAME_BITS   = 8 + WORD_BITS;

  // Width of the carrier phase counter (covers 0 .. 2*max(H)-1).
  localparam int         PH_W         = $clog2(2 * ((HALF0 > HALF1) ? HALF0 : HALF1));

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_TRIG      = 3'd2,
    ST_TX        = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

endpackage : system_top_pkg

`default_nettype wire

// File: rtl/spi_master.sv
//==============================================================================
// Module   : spi_master
// Purpose  : Mode-0 SPI read engine. On i_start it drops CS_n, shifts out
//            CMD_READ followed by WORD_BITS zeros (MSB first) and captures
//            WORD_BITS bits of MISO during the data phase.
// Ports    : i_clk, i_rst_n     - clock, async active-low reset
//            i_start            - one-clock request to run a frame
//            i_miso             - serial data from slave
//            o_sclk/o_mosi/o_cs_n - SPI bus
//            o_done             - one-clock pulse as CS_n returns high
//            o_word             - captured word (valid with o_done)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master
  import system_top_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_miso,
  output logic                 o_sclk,
  output logic                 o_mosi,
  output logic                 o_cs_n,
  output logic                 o_done,
  output logic [WORD_BITS-1:0] o_word
);

  localparam int DIV_W  = (SPI_HALF_DIV > 1) ? $clog2(SPI_HALF_DIV) : 1;
  localparam int HALF_W = $clog2(2 * FRAME_BITS + 1);

  localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(SPI_HALF_DIV - 1);
  // Half-periods 0..2*FRAME_BITS-1 are SCLK edges; the next one releases CS_n.
  localparam logic [HALF_W-1:0] c_last_half = HALF_W'(2 * FRAME_BITS);
  // First rising edge of the data phase (after 8 command bits).
  localparam logic [HALF_W-1:0] c_first_rx  = HALF_W'(2 * 8);

  logic                  r_busy;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_done;
  logic [DIV_W-1:0]      r_div;
  logic [HALF_W-1:0]     r_half;
  logic [FRAME_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0]  r_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_rx    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        // First MOSI bit is presented here, one half-period ahead of SCLK.
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_sclk  <= 1'b0;
        r_div   <= '0;
        r_half  <= '0;
        r_shift <= {CMD_READ, {WORD_BITS{1'b0}}};
        r_rx    <= '0;
      end else if (r_busy) begin
        if (r_div == c_div_last) begin
          r_div <= '0;
          if (r_half == c_last_half) begin
            r_busy <= 1'b0;
            r_cs_n <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_half <= r_half + HALF_W'(1);
            r_sclk <= ~r_sclk;
            if (!r_half[0]) begin
              // Even half index: SCLK rising edge, sample MISO in data phase.
              if (r_half >= c_first_rx) begin
                r_rx <= {r_rx[WORD_BITS-2:0], i_miso};
              end
            end else begin
              // Odd half index: SCLK falling edge, advance MOSI.
              r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_shift[FRAME_BITS-1];
  assign o_cs_n = r_cs_n;
  assign o_done = r_done;
  assign o_word = r_rx;

endmodule : spi_master

`default_nettype wire

// File: rtl/system_top.sv
//==============================================================================
// Module   : system_top
// Purpose  : Reads a word over SPI, pulses a frame trigger, then transmits
//            the word MSB first as FSK on an H-bridge (two diagonals with
//            dead time), and waits for a downstream done edge to repeat.
// Ports    : i_fpga_clock       - system clock
//            i_Rst_L            - async active-low reset
//            i_SPI_MISO         - SPI data in
//            i_Done_Trig        - async done request (rising edge)
//            o_SPI_Clk/o_SPI_MOSI/o_SPI_CS_n - SPI bus
//            o_Master_Trig      - frame-start pulse
//            F1Q1, F1Q4         - diagonal A gate drives
//            F2Q2, F2Q3         - diagonal B gate drives
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module system_top
  import system_top_pkg::*;
(
  input  logic i_fpga_clock,
  input  logic i_Rst_L,
  input  logic i_SPI_MISO,
  input  logic i_Done_Trig,
  output logic o_SPI_Clk,
  output logic o_SPI_MOSI,
  output logic o_SPI_CS_n,
  output logic o_Master_Trig,
  output logic F1Q1,
  output logic F1Q4,
  output logic F2Q2,
  output logic F2Q3
);

  localparam int CYC_W  = $clog2(CYC_PER_BIT);
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam int TRIG_W = $clog2(TRIG_LEN);

  localparam logic [PH_W-1:0]   c_half0     = PH_W'(HALF0);
  localparam logic [PH_W-1:0]   c_half1     = PH_W'(HALF1);
  localparam logic [PH_W-1:0]   c_dead      = PH_W'(DEAD);
  localparam logic [CYC_W-1:0]  c_cyc_last  = CYC_W'(CYC_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(WORD_BITS - 1);
  localparam logic [TRIG_W-1:0] c_trig_last = TRIG_W'(TRIG_LEN - 1);

  state_t                r_state;
  state_t                w_next;

  logic                  w_spi_start;
  logic                  w_spi_done;
  logic [WORD_BITS-1:0]  w_spi_word;

  logic                  r_done_meta;
  logic                  r_done_sync;
  logic                  r_done_prev;
  logic                  w_done_rise;

  logic [WORD_BITS-1:0]  r_word;
  logic [TRIG_W-1:0]     r_trig_cnt;
  logic [WORD_BITS-1:0]  r_tx_word;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [CYC_W-1:0]      r_cyc_cnt;
  logic [PH_W-1:0]       r_phase;
  logic                  r_diag_a;
  logic                  r_diag_b;

  logic [PH_W-1:0]       w_half;
  logic [PH_W-1:0]       w_period;
  logic                  w_phase_last;
  logic                  w_cyc_last;
  logic                  w_tx_end;
  logic                  w_a;
  logic                  w_b;

  //--------------------------------------------------------------------------
  // SPI read engine
  //--------------------------------------------------------------------------
  spi_master u_spi (
    .i_clk   (i_fpga_clock),
    .i_rst_n (i_Rst_L),
    .i_start (w_spi_start),
    .i_miso  (i_SPI_MISO),
    .o_sclk  (o_SPI_Clk),
    .o_mosi  (o_SPI_MOSI),
    .o_cs_n  (o_SPI_CS_n),
    .o_done  (w_spi_done),
    .o_word  (w_spi_word)
  );

  //--------------------------------------------------------------------------
  // Done request: two-flop synchronizer plus edge detect
  //--------------------------------------------------------------------------
  always_ff @(posedge i_fpga_clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_done_meta <= i_Done_Trig;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
    end
  end

  assign w_done_rise = r_done_sync & ~r_done_prev;

  //--------------------------------------------------------------------------
  // Carrier timing. The half-period follows the bit currently at the MSB of
  // the shift register, which only moves on a cycle boundary.
  //--------------------------------------------------------------------------
  assign w_half       = r_tx_word[WORD_BITS-1] ? c_half1 : c_half0;
  assign w_period     = {w_half[PH_W-2:0], 1'b0};
  assign w_phase_last = (r_phase == (w_period - PH_W'(1)));
  assign w_cyc_last   = (r_cyc_cnt == c_cyc_last);
  assign w_tx_end     = (r_state == ST_TX) && w_phase_last && w_cyc_last &&
                        (r_bit_cnt == c_bit_last);

  // The two windows are disjoint phase ranges, so A and B can never overlap.
  assign w_a = (r_state == ST_TX) && (r_phase < (w_half - c_dead));
  assign w_b = (r_state == ST_TX) && (r_phase >= w_half) &&
               (r_phase < (w_period - c_dead));

  //--------------------------------------------------------------------------
  // Datapath: word latch, trigger counter, FSK counters, gate registers
  //--------------------------------------------------------------------------
  always_ff @(posedge i_fpga_clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_word     <= '0;
      r_trig_cnt <= '0;
      r_tx_word  <= '0;
      r_bit_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_phase    <= '0;
      r_diag_a   <= 1'b0;
      r_diag_b   <= 1'b0;
    end else begin
      if ((r_state == ST_READ) && w_spi_done) begin
        r_word <= w_spi_word;
      end

      if (r_state == ST_TRIG) begin
        r_trig_cnt <= r_trig_cnt + TRIG_W'(1);
      end else begin
        r_trig_cnt <= '0;
      end

      if (r_state == ST_TX) begin
        if (w_phase_last) begin
          r_phase <= '0;
          if (w_cyc_last) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_tx_word <= {r_tx_word[WORD_BITS-2:0], 1'b0};
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
          end
        end else begin
          r_phase <= r_phase + PH_W'(1);
        end
      end else begin
        // Preload so the first TX clock already uses the latched MSB.
        r_tx_word <= r_word;
        r_bit_cnt <= '0;
        r_cyc_cnt <= '0;
        r_phase   <= '0;
      end

      r_diag_a <= w_a;
      r_diag_b <= w_b;
    end
  end

  assign F1Q1 = r_diag_a;
  assign F1Q4 = r_diag_a;
  assign F2Q2 = r_diag_b;
  assign F2Q3 = r_diag_b;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge i_fpga_clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = ST_READ;
      ST_READ:      if (w_spi_done) w_next = ST_TRIG;
      ST_TRIG:      if (r_trig_cnt == c_trig_last) w_next = ST_TX;
      ST_TX:        if (w_tx_end) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (w_done_rise) w_next = ST_READ;
      default:      w_next = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    o_Master_Trig = (r_state == ST_TRIG);
    // Kick the SPI engine on every entry into READ.
    w_spi_start   = (w_next == ST_READ) && (r_state != ST_READ);
  end

endmodule : system_top

`default_nettype wire

// File: tb/tb_system_top.sv
`default_nettype none

module tb_system_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miso;
  logic done_trig = 1'b0;
  logic sclk, mosi, cs_n, trig;
  logic f1q1, f1q4, f2q2, f2q3;

  system_top dut (
    .i_fpga_clock  (clk),
    .i_Rst_L       (rst_n),
    .i_SPI_MISO    (miso),
    .i_Done_Trig   (done_trig),
    .o_SPI_Clk     (sclk),
    .o_SPI_MOSI    (mosi),
    .o_SPI_CS_n    (cs_n),
    .o_Master_Trig (trig),
    .F1Q1          (f1q1),
    .F1Q4          (f1q4),
    .F2Q2          (f2q2),
    .F2Q3          (f2q3)
  );

  always #80 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // SPI slave model: data bit k of the word is presented after the
  // (8+k)-th SCLK rising edge, ready for the next one.
  logic [15:0] miso_word = 16'h0000;
  int rise_cnt = 0;
  always @(negedge cs_n) rise_cnt = 0;
  always @(posedge sclk) rise_cnt = rise_cnt + 1;
  assign miso = (rise_cnt >= 8 && rise_cnt < 24) ? miso_word[23 - rise_cnt] : 1'b0;

  // Done pulse generator, pulse_cnt clocks long.
  int pulse_cnt = 0;
  always @(negedge clk) begin
    if (pulse_cnt > 0) begin
      done_trig = 1'b1;
      pulse_cnt = pulse_cnt - 1;
    end else begin
      done_trig = 1'b0;
    end
  end

  // Bridge safety monitors.
  int overlap_cnt = 0;
  int diag_mis_cnt = 0;
  always @(negedge clk) begin
    if ((f1q1 | f1q4) & (f2q2 | f2q3)) overlap_cnt = overlap_cnt + 1;
    if ((f1q1 != f1q4) || (f2q2 != f2q3)) diag_mis_cnt = diag_mis_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_phase(output int lat, output int rises,
                            output logic [23:0] cap, output int span);
    int guard, t_first, t_last;
    logic prev;
    lat = 0; rises = 0; cap = '0; guard = 0; t_first = 0; t_last = 0;
    while (cs_n && lat < 10) begin
      @(negedge clk);
      lat = lat + 1;
    end
    prev = 1'b0;
    while (!cs_n && guard < 400) begin
      if (sclk && !prev) begin
        cap = {cap[22:0], mosi};
        if (rises == 0) t_first = cyc;
        t_last = cyc;
        rises = rises + 1;
      end
      prev = sclk;
      @(negedge clk);
      guard = guard + 1;
    end
    span = t_last - t_first;
  endtask

  task automatic trig_phase(output int width);
    int n;
    n = 0; width = 0;
    while (!trig && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    while (trig && width < 20) begin
      width = width + 1;
      @(negedge clk);
    end
  endtask

  // Called at a negedge where diagonal A has just been seen high.
  task automatic measure_cycle(output int a, output int d1, output int b,
                               output int d2, output bit tmo);
    a = 0; d1 = 0; b = 0; d2 = 0; tmo = 1'b0;
    while (f1q1 && a < 100) begin a = a + 1; @(negedge clk); end
    while (!f1q1 && !f2q2 && d1 < 10) begin d1 = d1 + 1; @(negedge clk); end
    while (f2q2 && b < 100) begin b = b + 1; @(negedge clk); end
    while (!f1q1 && !f2q2 && d2 < 8) begin d2 = d2 + 1; @(negedge clk); end
    if (a >= 100 || d1 >= 10 || b >= 100) tmo = 1'b1;
  endtask

  task automatic decode_frame(output logic [15:0] word, output int bad,
                              output int total, output int last_dead, output bit timeout);
    int n, a, d1, b, d2, h;
    bit tmo;
    word = '0; bad = 0; total = 0; last_dead = 0; timeout = 1'b0; h = 0; n = 0;
    while (!f1q1 && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!f1q1) begin
      timeout = 1'b1;
    end else begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 16; ci++) begin
          if (!timeout) begin
            measure_cycle(a, d1, b, d2, tmo);
            if (tmo) timeout = 1'b1;
            if (ci == 0) begin
              h = a + 2;
              word = {word[14:0], (a == 38)};
              if (a != 38 && a != 48) bad = bad + 1;
            end
            if (a != h - 2 || d1 != 2 || b != h - 2) bad = bad + 1;
            if (bi == 15 && ci == 15) begin
              last_dead = d2;
              total = total + a + d1 + b + 2;
            end else begin
              if (d2 != 2) bad = bad + 1;
              total = total + a + d1 + b + d2;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int lat, rises, span, width, bad, total, last_dead, n;
    logic [23:0] cap;
    logic [15:0] word;
    bit tmo;

    // ---------------- reset state ----------------
    miso_word = 16'hA5C3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, cs_n, sclk, mosi, trig, f1q1, f1q4, f2q2, f2q3}, 32'h80);
    rst_n = 1'b1;

    // ---------------- frame 1: A5C3 ----------------
    read_phase(lat, rises, cap, span);
    check("f1_cs_latency", lat, 1);
    check("f1_sclk_rises", rises, 24);
    check("f1_mosi_bits", {8'd0, cap}, 32'h030000);
    check("f1_sclk_span", span, 92);
    trig_phase(width);
    check("f1_trig_width", width, 8);
    pulse_cnt = 3;  // lands during TX, must be ignored
    decode_frame(word, bad, total, last_dead, tmo);
    check("f1_timeout", {31'd0, tmo}, 0);
    check("f1_word", {16'd0, word}, 32'hA5C3);
    check("f1_bad_cycles", bad, 0);
    check("f1_tx_clocks", total, 23040);
    check("f1_idle_after_tx", last_dead, 8);

    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (!cs_n) n = n + 1;
    end
    check("tx_pulse_ignored", n, 0);

    // ---------------- frame 2: 0000 via done in WAIT_DONE ----------------
    miso_word = 16'h0000;
    pulse_cnt = 3;
    n = 0;
    while (!done_trig && n < 10) begin
      @(negedge clk);
      n = n + 1;
    end
    lat = 0;
    while (cs_n && lat < 10) begin
      @(negedge clk);
      lat = lat + 1;
    end
    check("done_to_read_le4", {31'd0, (lat <= 4)}, 1);
    read_phase(lat, rises, cap, span);
    check("f2_sclk_rises", rises, 24);
    check("f2_mosi_bits", {8'd0, cap}, 32'h030000);
    trig_phase(width);
    check("f2_trig_width", width, 8);
    decode_frame(word, bad, total, last_dead, tmo);
    check("f2_timeout", {31'd0, tmo}, 0);
    check("f2_word", {16'd0, word}, 32'h0000);
    check("f2_bad_cycles", bad, 0);
    check("f2_tx_clocks", total, 25600);
    check("f2_idle_after_tx", last_dead, 8);

    // ---------------- frame 3: reset mid-TX ----------------
    miso_word = 16'h8001;
    pulse_cnt = 3;
    read_phase(lat, rises, cap, span);
    check("f3_sclk_rises", rises, 24);
    trig_phase(width);
    check("f3_trig_width", width, 8);
    n = 0;
    while (!f1q1 && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    check("f3_tx_started", {31'd0, f1q1}, 1);
    repeat (100) @(negedge clk);
    #37 rst_n = 1'b0;
    #1;
    check("midtx_reset_outputs", {24'd0, cs_n, sclk, mosi, trig, f1q1, f1q4, f2q2, f2q3}, 32'h80);
    repeat (2) @(negedge clk);
    check("held_reset_outputs", {24'd0, cs_n, sclk, mosi, trig, f1q1, f1q4, f2q2, f2q3}, 32'h80);
    miso_word = 16'hFFFF;
    rst_n = 1'b1;

    // ---------------- frame 4: fresh READ of FFFF ----------------
    read_phase(lat, rises, cap, span);
    check("f4_cs_latency", lat, 1);
    check("f4_sclk_rises", rises, 24);
    check("f4_mosi_bits", {8'd0, cap}, 32'h030000);
    check("f4_sclk_span", span, 92);
    trig_phase(width);
    check("f4_trig_width", width, 8);
    decode_frame(word, bad, total, last_dead, tmo);
    check("f4_timeout", {31'd0, tmo}, 0);
    check("f4_word", {16'd0, word}, 32'hFFFF);
    check("f4_bad_cycles", bad, 0);
    check("f4_tx_clocks", total, 20480);
    check("f4_idle_after_tx", last_dead, 8);

    check("diag_overlap", overlap_cnt, 0);
    check("diag_pair_equal", diag_mis_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_system_top

`default_nettype wire
